mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the MIPS datapath's load/store port. It decodes each data-memory access into one of the following:
- a synchronous-read data RAM,
- a keyboard scan-code FIFO,
- LED and sound-period registers,
- a free-running cycle counter.

It returns read data and asserts `stall` for RAM loads. The top level drives the datapath's `enable` with `~stall`.

## Interface
- `Dbits`, 32, data word width
- `DmemWords`, 1024, RAM depth in words; power of two
- `FifoDepth`, 8, keyboard FIFO depth; power of two, ≥2
- `DmemInit`, "dmem_data.mem", `$readmemh` init file for the RAM
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `mem_addr`  in  32  byte address from datapath (ALU result)
- `mem_writedata`  in  Dbits  store data
- `mem_wr`  in  1  store strobe from controller
- `mem_rd`  in  1  load strobe from controller (`wdsel==2'b10`)
- `mem_readdata`  out  Dbits  load data to datapath
- `stall`  out  1  high to freeze PC/register file for one cycle
- `kbd_valid`  in  1  one-cycle pulse, new scan code present
- `kbd_code`  in  8  scan code
- `kbd_ready`  out  1  FIFO not full (informational; the source does not wait)
- `led`  out  16  LED register
- `sound_period`  out  32  tone period register; 0 = silent

## Operation
Address map (word-aligned; `mem_addr[1:0]` is ignored):
- `0x1001_0000` + 4·i, i < `DmemWords`: data RAM, R/W.
- `0x1003_0000` KBD_DATA, R:
  - returns `{24'b0, head}` and pops the FIFO;
  - returns 0 with no pop when the FIFO is empty.
- `0x1003_0004` KBD_STATUS:
  - R: `{30'b0, overflow, nonempty}`;
  - W (any data): clears `overflow`.
- `0x1003_0008` LED, R/W: low 16 bits; reads return zero-extended.
- `0x1003_000C` SOUND, R/W: full 32 bits.
- `0x1003_0010` CYCLES, R only: 32-bit count of cycles since reset; wraps to 0; writes are ignored.
- Unmapped addresses: reads return 0; writes are ignored; no stall.

RAM load FSM, states `IDLE` and `DATA`:
- `IDLE`, with `mem_rd` and a RAM hit:
  - `stall`=1 combinationally;
  - RAM registers the read address;
  - next state is `DATA`.
- `DATA`:
  - `stall`=0;
  - `mem_readdata` = RAM output;
  - next state is `IDLE` unconditionally.
- This guarantees at most one stall per load, even though `mem_rd` stays high in `DATA`.

Other accesses:
- RAM stores complete in one cycle with no stall. Write and address are taken at the edge.
- Non-RAM reads are combinational, with no stall.
- A register write takes effect at the clock edge.
- `mem_wr` and `mem_rd` both high is illegal. The responder performs the write only.

Keyboard FIFO:
- Push when `kbd_valid`.
- When full and there is no simultaneous pop, the code is dropped and `overflow`←1 (sticky).
- Pop on a KBD_DATA read edge.
- Simultaneous push+pop when full: both succeed and the count is unchanged.
- Simultaneous push+pop when empty: the read returns 0 and the push is accepted.
- `kbd_ready` = count < `FifoDepth`.

## Timing
Reset values:
- `stall`=0, FSM=`IDLE`
- `led`=0, `sound_period`=0, CYCLES=0
- FIFO empty, `overflow`=0, `kbd_ready`=1
- RAM contents are not reset (loaded from `DmemInit`).

`mem_readdata` is 0 whenever `mem_rd`=0.

RAM load latency:
- 2 cycles: cycle N stall, cycle N+1 data.
- The datapath captures the loaded value at the end of N+1.

Register/FIFO read latency is 0 cycles. Pointers and count update at the edge.

Reset asserted in `DATA` returns the FSM to `IDLE` immediately. `stall` drops asynchronously.

CYCLES increments every cycle, including stall cycles.

## Structure
Package `mem_map_pkg` holds:
- address constants for the five registers and the RAM base;
- the `ram_fsm_t` enum {IDLE, DATA}.

One sub-module, `kbd_fifo`, parameterized by `FifoDepth`:
- circular buffer with wrap-around read/write pointers and a count of `$clog2(FifoDepth)+1` bits;
- push/pop/full/empty/overflow logic.

The RAM is inferred inline (synchronous read, synchronous write).

## Test plan
- RAM store `0xDEADBEEF` @`0x1001_0010`, then load the same address: `stall`=1 for exactly one cycle, then `mem_readdata`=`0xDEADBEEF`, then `stall`=0.
- LED write `0x0001_A5A5`: `led`=`0xA5A5`. LED readback returns `0x0000_A5A5`. Write `0x1003_0010`: CYCLES unaffected.
- Push codes 1..9 with `FifoDepth`=8:
  - `kbd_ready`=0 after the eighth push; the ninth is dropped and status reads 2'b11;
  - eight KBD_DATA reads return 1..8; the ninth returns 0;
  - a status write clears `overflow`.
- FIFO full plus simultaneous `kbd_valid` and KBD_DATA read: returns the oldest code, new code accepted, count stays 8, `overflow` stays 0.
- Reset mid-operation: assert `reset` low during `DATA` → `stall`=0, `led`=0, FIFO empty. After release, CYCLES reads 0 on the first cycle and increments by 1 per cycle, including stall cycles.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Address map and shared types for the MIPS data-memory responder.
// Word addresses are compared on bits [31:2]; the byte offset is ignored.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE        = 32'h1001_0000;
  localparam logic [31:0] KBD_DATA_ADDR   = 32'h1003_0000;
  localparam logic [31:0] KBD_STATUS_ADDR = 32'h1003_0004;
  localparam logic [31:0] LED_ADDR        = 32'h1003_0008;
  localparam logic [31:0] SOUND_ADDR      = 32'h1003_000C;
  localparam logic [31:0] CYCLES_ADDR     = 32'h1003_0010;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } ram_fsm_t;

  function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard scan-code FIFO: circular buffer with a sticky overflow flag.
// A push into a full FIFO only succeeds when a pop happens on the same edge.
module kbd_fifo #(
  parameter int Depth = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_code,
  input  logic       i_pop,
  input  logic       i_clr_ovf,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_ready
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [7:0]    r_buf [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full     = (r_count == CW'(Depth));
  assign o_empty    = (r_count == '0);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!w_full || w_do_pop);
  assign o_head     = r_buf[r_rd_ptr];
  assign o_overflow = r_overflow;
  assign o_ready    = !w_full;

  always_ff @(posedge clk) begin
    if (w_do_push) r_buf[r_wr_ptr] <= i_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      // A dropped code outranks a same-cycle clear so no overflow is ever lost.
      if (i_push && !w_do_push) r_overflow <= 1'b1;
      else if (i_clr_ovf)       r_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Data-memory responder: synchronous-read RAM with a one-cycle load stall,
// keyboard FIFO, LED/sound registers and a free-running cycle counter.
module mem_io_responder
  import mem_map_pkg::*;
#(
  parameter int    Dbits     = 32,
  parameter int    DmemWords = 1024,
  parameter int    FifoDepth = 8,
  parameter string DmemInit  = "dmem_data.mem"
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      mem_addr,
  input  logic [Dbits-1:0] mem_writedata,
  input  logic             mem_wr,
  input  logic             mem_rd,
  output logic [Dbits-1:0] mem_readdata,
  output logic             stall,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_code,
  output logic             kbd_ready,
  output logic [15:0]      led,
  output logic [31:0]      sound_period
);

  localparam int AW = $clog2(DmemWords);

  ram_fsm_t r_state;
  ram_fsm_t w_next_state;

  logic [Dbits-1:0] r_mem [DmemWords];
  logic [Dbits-1:0] r_rdata;
  logic [15:0]      r_led;
  logic [31:0]      r_sound;
  logic [31:0]      r_cycles;

  logic [31:0]   w_ram_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_hit;
  logic          w_rd;
  logic          w_ld_start;
  logic          w_hit_kdata, w_hit_kstat, w_hit_led, w_hit_sound, w_hit_cycles;
  logic [7:0]    w_kbd_head;
  logic          w_kbd_empty;
  logic          w_kbd_ovf;

  assign w_ram_off = mem_addr - RAM_BASE;
  assign w_ram_hit = w_ram_off < 32'(DmemWords * 4);
  assign w_ram_idx = w_ram_off[AW+1:2];

  // A simultaneous store and load performs only the store.
  assign w_rd       = mem_rd && !mem_wr;
  assign w_ld_start = (r_state == IDLE) && w_rd && w_ram_hit;

  assign w_hit_kdata  = word_match(mem_addr[31:2], KBD_DATA_ADDR[31:2]);
  assign w_hit_kstat  = word_match(mem_addr[31:2], KBD_STATUS_ADDR[31:2]);
  assign w_hit_led    = word_match(mem_addr[31:2], LED_ADDR[31:2]);
  assign w_hit_sound  = word_match(mem_addr[31:2], SOUND_ADDR[31:2]);
  assign w_hit_cycles = word_match(mem_addr[31:2], CYCLES_ADDR[31:2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    case (r_state)
      IDLE: if (w_rd && w_ram_hit) begin
        stall        = reset;
        w_next_state = DATA;
      end
      DATA: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the RAM array and its read register carry no reset; only control
  // state is cleared, which is what lets this map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_wr && w_ram_hit) r_mem[w_ram_idx] <= mem_writedata;
    if (w_ld_start)          r_rdata <= r_mem[w_ram_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led    <= '0;
      r_sound  <= '0;
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (mem_wr && w_hit_led)   r_led   <= mem_writedata[15:0];
      if (mem_wr && w_hit_sound) r_sound <= 32'(mem_writedata);
    end
  end

  kbd_fifo #(
    .Depth(FifoDepth)
  ) u_kbd_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .i_push     (kbd_valid),
    .i_code     (kbd_code),
    .i_pop      (w_rd && w_hit_kdata),
    .i_clr_ovf  (mem_wr && w_hit_kstat),
    .o_head     (w_kbd_head),
    .o_empty    (w_kbd_empty),
    .o_overflow (w_kbd_ovf),
    .o_ready    (kbd_ready)
  );

  always_comb begin
    mem_readdata = '0;
    if (w_rd) begin
      if (r_state == DATA)  mem_readdata = r_rdata;
      else if (w_hit_kdata) mem_readdata = w_kbd_empty ? '0 : Dbits'(w_kbd_head);
      else if (w_hit_kstat) mem_readdata = Dbits'({w_kbd_ovf, !w_kbd_empty});
      else if (w_hit_led)   mem_readdata = Dbits'(r_led);
      else if (w_hit_sound) mem_readdata = Dbits'(r_sound);
      else if (w_hit_cycles) mem_readdata = Dbits'(r_cycles);
    end
  end

  assign led          = r_led;
  assign sound_period = r_sound;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM load stall, registers, keyboard
// FIFO edge cases and reset during a load.
module tb_mem_io_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_writedata = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] mem_readdata;
  logic        stall;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_code = '0;
  logic        kbd_ready;
  logic [15:0] led;
  logic [31:0] sound_period;

  int          total = 0;
  int          bad   = 0;
  int unsigned ncyc  = 0;

  mem_io_responder dut (
    .clock         (clock),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_wr        (mem_wr),
    .mem_rd        (mem_rd),
    .mem_readdata  (mem_readdata),
    .stall         (stall),
    .kbd_valid     (kbd_valid),
    .kbd_code      (kbd_code),
    .kbd_ready     (kbd_ready),
    .led           (led),
    .sound_period  (sound_period)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; ncyc models the CYCLES register.
  task automatic tick();
    @(posedge clock);
    ncyc++;
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata);
    mem_wr        = wr;
    mem_rd        = rd;
    mem_addr      = addr;
    mem_writedata = wdata;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_sound", sound_period, 32'h0);
    check("rst_ready", 32'(kbd_ready), 32'h1);
    check("rst_rdata", mem_readdata, 32'h0);

    reset = 1'b1;
    ncyc  = 0;
    drive(0, 1, 32'h1003_0010, 0);
    check("cyc_first", mem_readdata, 32'h0);
    tick();
    check("cyc_one", mem_readdata, 32'h1);
    tick();
    check("cyc_two", mem_readdata, 32'h2);

    // RAM store then load: one stall cycle, then data
    drive(1, 0, 32'h1001_0010, 32'hDEAD_BEEF);
    check("st_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 1, 32'h1001_0010, 0);
    check("ld_stall_n", 32'(stall), 32'h1);
    tick();
    check("ld_stall_n1", 32'(stall), 32'h0);
    check("ld_data", mem_readdata, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 32'h1001_0010, 0);
    check("ld_after_stall", 32'(stall), 32'h0);
    check("ld_after_rdata", mem_readdata, 32'h0);

    // RAM bounds: first and last word, one past the end is unmapped
    drive(1, 0, 32'h1001_0000, 32'hA1A1_0000);
    tick();
    drive(1, 0, 32'h1001_0FFC, 32'h1234_5678);
    tick();
    drive(1, 0, 32'h1001_1000, 32'h0BAD_0BAD);
    check("oob_wr_stall", 32'(stall), 32'h0);
    tick();
    drive(0, 1, 32'h1001_1000, 0);
    check("oob_rd_stall", 32'(stall), 32'h0);
    check("oob_rd_data", mem_readdata, 32'h0);
    tick();
    drive(0, 1, 32'h1001_0FFC, 0);
    check("last_stall", 32'(stall), 32'h1);
    tick();
    check("last_data", mem_readdata, 32'h1234_5678);
    tick();
    drive(0, 1, 32'h1001_0000, 0);
    tick();
    check("first_data", mem_readdata, 32'hA1A1_0000);
    tick();

    // store and load together: store only, no stall
    drive(1, 1, 32'h1001_0020, 32'h0000_0077);
    check("wrrd_stall", 32'(stall), 32'h0);
    check("wrrd_rdata", mem_readdata, 32'h0);
    tick();
    drive(0, 1, 32'h1001_0020, 0);
    tick();
    check("wrrd_data", mem_readdata, 32'h0000_0077);
    tick();

    drive(0, 1, 32'h1003_0014, 0);
    check("unmap_rdata", mem_readdata, 32'h0);
    check("unmap_stall", 32'(stall), 32'h0);
    drive(0, 1, 32'h0000_0000, 0);
    check("zero_rdata", mem_readdata, 32'h0);

    // LED / SOUND / CYCLES registers
    drive(1, 0, 32'h1003_0008, 32'h0001_A5A5);
    tick();
    check("led_out", 32'(led), 32'h0000_A5A5);
    drive(0, 1, 32'h1003_0008, 0);
    check("led_rd", mem_readdata, 32'h0000_A5A5);
    drive(0, 1, 32'h1003_000A, 0);
    check("led_rd_byteoff", mem_readdata, 32'h0000_A5A5);
    drive(1, 0, 32'h1003_000C, 32'h8000_0001);
    tick();
    check("sound_out", sound_period, 32'h8000_0001);
    drive(0, 1, 32'h1003_000C, 0);
    check("sound_rd", mem_readdata, 32'h8000_0001);
    drive(1, 0, 32'h1003_0010, 32'h0000_0000);
    tick();
    drive(0, 1, 32'h1003_0010, 0);
    check("cyc_nowrite", mem_readdata, ncyc);

    // FIFO fill past capacity
    drive(0, 0, 32'h0, 0);
    for (int i = 1; i <= 9; i++) begin
      kbd_valid = 1'b1;
      kbd_code  = 8'(i);
      tick();
      if (i == 7) check("ready_7", 32'(kbd_ready), 32'h1);
      if (i == 8) check("ready_8", 32'(kbd_ready), 32'h0);
    end
    kbd_valid = 1'b0;
    drive(0, 1, 32'h1003_0004, 0);
    check("status_full_ovf", mem_readdata, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 32'h1003_0000, 0);
      check("kbd_pop", mem_readdata, 32'(i));
      tick();
    end
    drive(0, 1, 32'h1003_0000, 0);
    check("kbd_pop_empty", mem_readdata, 32'h0);
    tick();
    drive(0, 1, 32'h1003_0004, 0);
    check("status_empty_ovf", mem_readdata, 32'h2);
    drive(1, 0, 32'h1003_0004, 32'hFFFF_FFFF);
    tick();
    drive(0, 1, 32'h1003_0004, 0);
    check("status_cleared", mem_readdata, 32'h0);
    check("ready_empty", 32'(kbd_ready), 32'h1);

    // full FIFO with simultaneous push and pop
    drive(0, 0, 32'h0, 0);
    for (int i = 0; i < 8; i++) begin
      kbd_valid = 1'b1;
      kbd_code  = 8'(8'h10 + i);
      tick();
    end
    check("ready_full2", 32'(kbd_ready), 32'h0);
    kbd_code = 8'h18;
    drive(0, 1, 32'h1003_0000, 0);
    check("pushpop_full_rd", mem_readdata, 32'h10);
    tick();
    kbd_valid = 1'b0;
    check("pushpop_full_ready", 32'(kbd_ready), 32'h0);
    drive(0, 1, 32'h1003_0004, 0);
    check("pushpop_full_status", mem_readdata, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 32'h1003_0000, 0);
      check("pushpop_drain", mem_readdata, 32'(8'h10 + i));
      tick();
    end
    drive(0, 1, 32'h1003_0000, 0);
    check("drain_empty", mem_readdata, 32'h0);
    drive(0, 1, 32'h1003_0004, 0);
    check("drain_status", mem_readdata, 32'h0);

    // empty FIFO with simultaneous push and pop
    kbd_valid = 1'b1;
    kbd_code  = 8'h55;
    drive(0, 1, 32'h1003_0000, 0);
    check("pushpop_empty_rd", mem_readdata, 32'h0);
    tick();
    kbd_valid = 1'b0;
    drive(0, 1, 32'h1003_0000, 0);
    check("pushpop_empty_kept", mem_readdata, 32'h55);
    tick();
    drive(0, 1, 32'h1003_0004, 0);
    check("pushpop_empty_status", mem_readdata, 32'h0);

    // reset asserted while the FSM is in DATA
    drive(1, 0, 32'h1003_0008, 32'h0000_00FF);
    tick();
    kbd_valid = 1'b1;
    kbd_code  = 8'h42;
    drive(1, 0, 32'h1003_000C, 32'h0000_1234);
    tick();
    kbd_valid = 1'b0;
    drive(0, 1, 32'h1001_0010, 0);
    check("mid_stall", 32'(stall), 32'h1);
    tick();
    check("mid_data_stall", 32'(stall), 32'h0);
    reset = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall), 32'h0);
    check("rstmid_led", 32'(led), 32'h0);
    check("rstmid_sound", sound_period, 32'h0);
    check("rstmid_ready", 32'(kbd_ready), 32'h1);
    @(posedge clock);
    #1;
    check("rstheld_stall", 32'(stall), 32'h0);
    mem_rd = 1'b0;
    reset  = 1'b1;
    ncyc   = 0;
    drive(0, 1, 32'h1003_0010, 0);
    check("rel_cyc0", mem_readdata, 32'h0);
    tick();
    check("rel_cyc1", mem_readdata, 32'h1);
    drive(0, 1, 32'h1003_0004, 0);
    check("rel_status", mem_readdata, 32'h0);
    drive(0, 1, 32'h1003_0000, 0);
    check("rel_kbd_empty", mem_readdata, 32'h0);
    drive(0, 1, 32'h1001_0010, 0);
    check("rel_ld_stall", 32'(stall), 32'h1);
    tick();
    check("rel_ld_data", mem_readdata, 32'hDEAD_BEEF);
    tick();
    drive(0, 1, 32'h1003_0010, 0);
    check("rel_cyc_after_stall", mem_readdata, 32'h3);
    check("rel_cyc_model", mem_readdata, ncyc);
    drive(0, 0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
